// File: rtl/funprof_tracker.sv
// Call/return profiler: decodes MicroBlaze calls/returns, keeps a shadow call
// stack of {call-site pc, entry timestamp} and emits one record per matched return.
module funprof_tracker #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned REG_FORM   = 0,
    parameter int unsigned RET_ALL    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [0:31]                instr,
    input  logic                       insvalid,
    input  logic [ADDR_W-1:0]          pc,
    input  logic                       enable,
    input  logic                       clr,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [ADDR_W-1:0]          rec_pc,
    output logic [CNT_W-1:0]           rec_cycles,
    output logic [$clog2(DEPTH)-1:0]   rec_depth,
    output logic                       ovf,
    output logic                       unf,
    output logic                       drop
);

    localparam int unsigned DEP_W = $clog2(DEPTH);
    localparam int unsigned SP_W  = DEP_W + 1;
    localparam int unsigned FP_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FC_W  = FP_W + 1;

    // Instruction field decode (MSB-first numbering)
    logic [5:0]  opc;
    logic [10:0] op11;
    logic [4:0]  fld_a;
    logic [4:0]  fld_d;
    logic        call_hit;
    logic        ret_hit;
    logic        unused_bits;

    assign opc         = instr[0:5];
    assign op11        = instr[0:10];
    assign fld_d       = instr[6:10];
    assign fld_a       = instr[11:15];
    assign unused_bits = ^instr[16:31];

    always_comb begin
        call_hit = 1'b0;
        ret_hit  = 1'b0;
        if (insvalid && enable) begin
            call_hit = ((opc == 6'b101110) || ((REG_FORM != 0) && (opc == 6'b100110)))
                       && ((fld_a == 5'b11100) || (fld_a == 5'b10100));
            ret_hit  = (op11 == 11'b10110110000)
                       || ((RET_ALL != 0) && (opc == 6'b101101)
                           && ((fld_d == 5'b10001) || (fld_d == 5'b10010) || (fld_d == 5'b10100)));
        end
    end

    // Stage 1: decode results, pc and timestamp
    logic              call_q;
    logic              ret_q;
    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  ts_q;
    logic [CNT_W-1:0]  ts;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            call_q <= 1'b0;
            ret_q  <= 1'b0;
            pc_q   <= '0;
            ts_q   <= '0;
            ts     <= '0;
        end else begin
            call_q <= call_hit;
            ret_q  <= ret_hit;
            pc_q   <= pc;
            ts_q   <= ts;
            ts     <= ts + CNT_W'(1);
        end
    end

    // Stage 2: shadow stack
    logic [ADDR_W-1:0] stk_pc [DEPTH];
    logic [CNT_W-1:0]  stk_ts [DEPTH];
    logic [SP_W-1:0]   sp;
    logic [CNT_W-1:0]  lost;
    logic              stk_full;
    logic              stk_empty;
    logic              push;
    logic              pop_stk;
    logic [DEP_W-1:0]  top_idx;
    logic [ADDR_W-1:0] wr_pc;
    logic [CNT_W-1:0]  wr_cyc;

    assign stk_full  = (sp == SP_W'(DEPTH));
    assign stk_empty = (sp == '0);
    assign push      = call_q && !stk_full;
    assign pop_stk   = ret_q && (lost == '0) && !stk_empty;
    assign top_idx   = DEP_W'(sp - SP_W'(1));
    assign wr_pc     = stk_pc[top_idx];
    assign wr_cyc    = ts_q - stk_ts[top_idx];

    always_ff @(posedge clk) begin
        if (push) begin
            stk_pc[DEP_W'(sp)] <= pc_q;
            stk_ts[DEP_W'(sp)] <= ts_q;
        end
    end

    // Record FIFO state
    logic [ADDR_W-1:0] f_pc  [FIFO_DEPTH];
    logic [CNT_W-1:0]  f_cyc [FIFO_DEPTH];
    logic [DEP_W-1:0]  f_dep [FIFO_DEPTH];
    logic [FP_W-1:0]   wr_ptr;
    logic [FP_W-1:0]   rd_ptr;
    logic [FC_W-1:0]   cnt;
    logic              f_full;
    logic              f_pop;
    logic              f_wr;
    logic [FP_W-1:0]   rd_next;
    logic [FC_W-1:0]   cnt_next;
    logic [ADDR_W-1:0] head_pc;
    logic [CNT_W-1:0]  head_cyc;
    logic [DEP_W-1:0]  head_dep;

    assign f_full = (cnt == FC_W'(FIFO_DEPTH));
    assign f_pop  = rec_valid && rec_ready;
    assign f_wr   = pop_stk && (!f_full || f_pop);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sp   <= '0;
            lost <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
            drop <= 1'b0;
        end else begin
            if (push) begin
                sp <= sp + SP_W'(1);
            end
            if (call_q && stk_full) begin
                ovf <= 1'b1;
                if (lost != {CNT_W{1'b1}}) begin
                    lost <= lost + CNT_W'(1);
                end
            end
            if (ret_q) begin
                if (lost != '0) begin
                    lost <= lost - CNT_W'(1);
                end else if (!stk_empty) begin
                    sp <= sp - SP_W'(1);
                end else begin
                    unf <= 1'b1;
                end
            end
            if (pop_stk && f_full && !f_pop) begin
                drop <= 1'b1;
            end
        end
    end

    // Next head: the freshly written entry when it lands on the new read slot
    always_comb begin
        rd_next  = f_pop ? (rd_ptr + FP_W'(1)) : rd_ptr;
        cnt_next = cnt + FC_W'(f_wr) - FC_W'(f_pop);
        head_pc  = f_pc[rd_next];
        head_cyc = f_cyc[rd_next];
        head_dep = f_dep[rd_next];
        if (f_wr && (wr_ptr == rd_next)) begin
            head_pc  = wr_pc;
            head_cyc = wr_cyc;
            head_dep = top_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (f_wr) begin
            f_pc[wr_ptr]  <= wr_pc;
            f_cyc[wr_ptr] <= wr_cyc;
            f_dep[wr_ptr] <= top_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            rec_valid  <= 1'b0;
            rec_pc     <= '0;
            rec_cycles <= '0;
            rec_depth  <= '0;
        end else begin
            if (f_wr) begin
                wr_ptr <= wr_ptr + FP_W'(1);
            end
            rd_ptr    <= rd_next;
            cnt       <= cnt_next;
            rec_valid <= (cnt_next != '0);
            if (cnt_next != '0) begin
                rec_pc     <= head_pc;
                rec_cycles <= head_cyc;
                rec_depth  <= head_dep;
            end
        end
    end

endmodule
